iterative_shifter: RTL
======================

# iterative_shifter

Parametrised multi-cycle shifter for the processor's execute stage. It generalises the fixed-amount, fixed-width shift cells into a single WIDTH-bit unit supporting logical left, logical right and arithmetic right shifts by any run-time amount. The unit resolves one shift-amount bit per clock, so the datapath needs only one 2^k shift stage instead of a full barrel array. The ALU control drives it with a start/done handshake, the same way as the multi-cycle multiplier/divider.

## Interface
- WIDTH, 32: datapath width; must be a power of two, ≥ 2.
- SHAMT_W, 5: shift-amount width; must equal log2(WIDTH).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- data_in  in  WIDTH  operand; latched with start.
- shamt  in  SHAMT_W  shift amount; latched with start.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  shifted value; held until the next done.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - On start, latch data_in into the working register, and latch op and shamt.
  - Clear the stage counter k to 0 and go to SHIFT.
- SHIFT, one stage per cycle:
  - If shamt_latched[k] = 1, shift the working register by 2^k. Otherwise hold it.
  - k increments each cycle.
  - After the stage with k = SHAMT_W−1, load the result register from the shifted value and go to DONE.
- Fill rules for each stage:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the latched operand's MSB enter at the MSB, so the sign is preserved across all stages.
- DONE: done = 1 for exactly one cycle.
  - If start is high, a new operation is latched and the FSM goes to SHIFT. This allows back-to-back operation.
  - Otherwise the FSM returns to IDLE.
- start while in SHIFT is ignored. It is not queued and does not disturb the operation in flight.
- Operand inputs are don't-care except in the cycle where start is accepted.
- shamt = 0 still runs all SHAMT_W stages; the result equals data_in.
- Shifts are always modulo WIDTH; no over-range amount exists, because shamt is exactly log2(WIDTH) bits.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - state = IDLE, k = 0, busy = 0, done = 0, result = 0, working register = 0.
- Reset asserted mid-operation aborts the operation. done never pulses for the aborted request, and result reads 0 after the reset edge.
- Latency:
  - start is sampled high at the end of cycle 0.
  - busy is high in cycles 1 … SHAMT_W.
  - done is high, and result is valid, in cycle SHAMT_W+1. For WIDTH=32, done is in cycle 6.
- Throughput: one operation per SHAMT_W+1 cycles when start is held or reissued in the DONE cycle.
- busy and done are never high together.
- done and busy are registered outputs with no combinational path from inputs.

## Configuration
- Macro: ITERATIVE_SHIFTER_ROTATE_EN.
- Defined:
  - op = 11 performs rotate right: bits shifted out at the LSB re-enter at the MSB in each stage.
  - The extra wrap-around mux is compiled into the stage logic.
- Not defined:
  - No rotate logic is present.
  - op = 11 is decoded as SRL (zero fill). Latency and handshake are unchanged.

## Test plan
- SRA, data_in=0x8000_0000, shamt=8, start in cycle 0 → busy in cycles 1–5, done in cycle 6 only, result=0xFF80_0000.
- SRL with the same operand, shamt=8 → result=0x0080_0000. SLL, data_in=0x0000_0001, shamt=31 → result=0x8000_0000.
- shamt=0, SRA, data_in=0xDEAD_BEEF → result=0xDEAD_BEEF, done still in cycle 6. Then start held high in the DONE cycle with SLL, 0x1, shamt=4 → second done 6 cycles later, result=0x0000_0010.
- start pulsed in cycle 3 with different operands during an SRL of 0xF000_0000 by 4 → ignored. A single done in cycle 6 with result=0x0F00_0000.
- reset asserted in cycle 3 of an operation → busy=0, done=0, result=0 from cycle 4; no done pulse appears in cycle 6.
- With ITERATIVE_SHIFTER_ROTATE_EN: op=11, data_in=0x0000_00F1, shamt=4 → result=0x1000_000F. Without the macro, the same stimulus → 0x0000_000F.

Source files
------------

// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle SLL/SRL/SRA unit resolving one shift-amount bit per clock.
// Optional rotate-right for op=11 is enabled by defining ITERATIVE_SHIFTER_ROTATE_EN.
module iterative_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);
   localparam logic [SHAMT_W-1:0] K_ONE  = SHAMT_W'(1'b1);

   state_t             state_q, state_d;
   logic [SHAMT_W-1:0] k_q, k_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [1:0]         op_q, op_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [SHAMT_W-1:0] amt_s;
   logic [WIDTH-1:0]   fill_mask_s;
   logic [WIDTH-1:0]   stage_s;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
   logic [SHAMT_W-1:0] rot_back_s;
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

   // Single 2^k shift stage applied to the working register.
   always_comb begin
      amt_s       = K_ONE << k_q;
      fill_mask_s = ~({WIDTH{1'b1}} >> amt_s);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      rot_back_s  = -amt_s;
`endif
      case (op_q)
         2'b00: stage_s = work_q << amt_s;
         2'b01: stage_s = work_q >> amt_s;
         2'b10: begin
            // SRA fill comes from the operand sign captured at start.
            if (sign_q) begin
               stage_s = (work_q >> amt_s) | fill_mask_s;
            end else begin
               stage_s = work_q >> amt_s;
            end
         end
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
         2'b11: stage_s = (work_q >> amt_s) | (work_q << rot_back_s);
`else
         2'b11: stage_s = work_q >> amt_s;
`endif
         default: stage_s = work_q;
      endcase
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      work_d   = work_q;
      op_d     = op_q;
      shamt_d  = shamt_q;
      sign_d   = sign_q;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               work_d  = data_in;
               op_d    = op;
               shamt_d = shamt;
               sign_d  = data_in[WIDTH-1];
               k_d     = {SHAMT_W{1'b0}};
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            // shamt_q is consumed LSB-first, so bit 0 always belongs to stage k.
            if (shamt_q[0]) begin
               work_d = stage_s;
            end else begin
               work_d = work_q;
            end
            shamt_d = shamt_q >> 1'b1;
            if (k_q == K_LAST) begin
               result_d = work_d;
               state_d  = S_DONE;
            end else begin
               k_d = k_q + K_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         k_q      <= {SHAMT_W{1'b0}};
         work_q   <= {WIDTH{1'b0}};
         op_q     <= 2'b00;
         shamt_q  <= {SHAMT_W{1'b0}};
         sign_q   <= 1'b0;
         result_q <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         work_q   <= work_d;
         op_q     <= op_d;
         shamt_q  <= shamt_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

endmodule
